// File: rtl/reg_ref_file_pkg.sv
// reg_ref_file_pkg: shared bus widths, zero register index and entry layout for the
// renaming register file.
package reg_ref_file_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int DATA_W     = 32;
    localparam int ROB_ADDR_W = 4;
    localparam int REG_NUM    = 1 << REG_ADDR_W;

    localparam logic [REG_ADDR_W-1:0] ZERO_REG = '0;

    // One architectural register: committed value plus rename ownership.
    typedef struct packed {
        logic [DATA_W-1:0]     value;
        logic                  busy;
        logic [ROB_ADDR_W-1:0] tag;
    } entry_t;

endpackage

// File: rtl/reg_ref_file_read_port.sv
// reg_ref_file_read_port: combinational lookup of one register file read port.
// Ports: en/addr select the source register; regs is the full entry array;
// is_ref/data return either the committed value or the zero-extended owning ROB tag.
// With REGFILE_COMMIT_BYPASS_EN defined, the commit_* inputs exist and a commit that
// retires the current owner this cycle is forwarded as a plain value.
module reg_ref_file_read_port
    import reg_ref_file_pkg::*;
(
    input  logic                  en,
    input  logic [REG_ADDR_W-1:0] addr,
    input  entry_t [REG_NUM-1:0]  regs,
`ifdef REGFILE_COMMIT_BYPASS_EN
    input  logic                  commit_en,
    input  logic [REG_ADDR_W-1:0] commit_addr,
    input  logic [ROB_ADDR_W-1:0] commit_ref,
    input  logic [DATA_W-1:0]     commit_data,
`endif
    output logic                  is_ref,
    output logic [DATA_W-1:0]     data
);

    entry_t e;
    logic   hit;
    logic   byp;

    always_comb begin
        e   = regs[addr];
        hit = en && (addr != ZERO_REG);
`ifdef REGFILE_COMMIT_BYPASS_EN
        byp = hit && commit_en && (commit_addr == addr) && e.busy && (e.tag == commit_ref);
`else
        byp = 1'b0;
`endif
        is_ref = hit && e.busy && !byp;
`ifdef REGFILE_COMMIT_BYPASS_EN
        data = !hit ? '0 : byp ? commit_data : e.busy ? DATA_W'(e.tag) : e.value;
`else
        data = !hit ? '0 : e.busy ? DATA_W'(e.tag) : e.value;
`endif
    end

endmodule

// File: rtl/reg_ref_file.sv
// reg_ref_file: 32-entry register file with ROB-tag renaming, commit and flush.
// Ports: clk, rst (sync, active-high); two read ports (reg_read_en/addr in,
// reg_read_is_ref/data out); rename (reg_write_en/addr/ref); commit
// (commit_en/addr/ref/data); flush clears every pending rename.
// Optional macro REGFILE_COMMIT_BYPASS_EN forwards same-cycle commits to the reads.
module reg_ref_file
    import reg_ref_file_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  reg_read_en_1,
    input  logic [REG_ADDR_W-1:0] reg_read_addr_1,
    output logic                  reg_read_is_ref_1,
    output logic [DATA_W-1:0]     reg_read_data_1,
    input  logic                  reg_read_en_2,
    input  logic [REG_ADDR_W-1:0] reg_read_addr_2,
    output logic                  reg_read_is_ref_2,
    output logic [DATA_W-1:0]     reg_read_data_2,
    input  logic                  reg_write_en,
    input  logic [REG_ADDR_W-1:0] reg_write_addr,
    input  logic [ROB_ADDR_W-1:0] reg_write_ref,
    input  logic                  commit_en,
    input  logic [REG_ADDR_W-1:0] commit_addr,
    input  logic [ROB_ADDR_W-1:0] commit_ref,
    input  logic [DATA_W-1:0]     commit_data,
    input  logic                  flush
);

    entry_t [REG_NUM-1:0] regs;

    // Later assignments win: a same-cycle rename overrides the busy clear of a
    // commit, while flush discards the rename and clears every busy bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            regs <= '0;
        end else begin
            if (commit_en && commit_addr != ZERO_REG) begin
                regs[commit_addr].value <= commit_data;
                if (regs[commit_addr].tag == commit_ref)
                    regs[commit_addr].busy <= 1'b0;
            end
            if (flush) begin
                for (int i = 0; i < REG_NUM; i++)
                    regs[i].busy <= 1'b0;
            end else if (reg_write_en && reg_write_addr != ZERO_REG) begin
                regs[reg_write_addr].busy <= 1'b1;
                regs[reg_write_addr].tag  <= reg_write_ref;
            end
        end
    end

    reg_ref_file_read_port u_rd1 (
        .en          (reg_read_en_1),
        .addr        (reg_read_addr_1),
        .regs        (regs),
`ifdef REGFILE_COMMIT_BYPASS_EN
        .commit_en   (commit_en),
        .commit_addr (commit_addr),
        .commit_ref  (commit_ref),
        .commit_data (commit_data),
`endif
        .is_ref      (reg_read_is_ref_1),
        .data        (reg_read_data_1)
    );

    reg_ref_file_read_port u_rd2 (
        .en          (reg_read_en_2),
        .addr        (reg_read_addr_2),
        .regs        (regs),
`ifdef REGFILE_COMMIT_BYPASS_EN
        .commit_en   (commit_en),
        .commit_addr (commit_addr),
        .commit_ref  (commit_ref),
        .commit_data (commit_data),
`endif
        .is_ref      (reg_read_is_ref_2),
        .data        (reg_read_data_2)
    );

endmodule

// File: tb/tb_reg_ref_file.sv
// tb_reg_ref_file: directed and randomized checks of reg_ref_file against a
// behavioural model of register values and rename ownership.
module tb_reg_ref_file;
    import reg_ref_file_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                  rst;
    logic                  re1, re2;
    logic [REG_ADDR_W-1:0] ra1, ra2;
    logic                  ref1, ref2;
    logic [DATA_W-1:0]     rd1, rd2;
    logic                  we;
    logic [REG_ADDR_W-1:0] wa;
    logic [ROB_ADDR_W-1:0] wr;
    logic                  ce;
    logic [REG_ADDR_W-1:0] ca;
    logic [ROB_ADDR_W-1:0] cr;
    logic [DATA_W-1:0]     cd;
    logic                  flush;

    reg_ref_file dut (
        .clk               (clk),
        .rst               (rst),
        .reg_read_en_1     (re1),
        .reg_read_addr_1   (ra1),
        .reg_read_is_ref_1 (ref1),
        .reg_read_data_1   (rd1),
        .reg_read_en_2     (re2),
        .reg_read_addr_2   (ra2),
        .reg_read_is_ref_2 (ref2),
        .reg_read_data_2   (rd2),
        .reg_write_en      (we),
        .reg_write_addr    (wa),
        .reg_write_ref     (wr),
        .commit_en         (ce),
        .commit_addr       (ca),
        .commit_ref        (cr),
        .commit_data       (cd),
        .flush             (flush)
    );

    int checks = 0;
    int errors = 0;

    logic [31:0] m_val [32];
    logic        m_busy[32];
    logic [3:0]  m_tag [32];

    task automatic check(input string name, input logic [32:0] obs, input logic [32:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, obs, exp);
        end
    endtask

    // What a read should return given the architectural state before this edge.
    function automatic logic [32:0] model_read(input logic en, input logic [4:0] a);
        if (!en || a == 0) return 33'd0;
`ifdef REGFILE_COMMIT_BYPASS_EN
        if (ce && ca == a && m_busy[a] && m_tag[a] == cr) return {1'b0, cd};
`endif
        if (m_busy[a]) return {1'b1, 28'd0, m_tag[a]};
        return {1'b0, m_val[a]};
    endfunction

    task automatic step();
        #1;
        if (!rst) begin
            check("port1", {ref1, rd1}, model_read(re1, ra1));
            check("port2", {ref2, rd2}, model_read(re2, ra2));
        end
        @(posedge clk);
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                m_val[i] = 0; m_busy[i] = 0; m_tag[i] = 0;
            end
        end else begin
            if (ce && ca != 0) begin
                m_val[ca] = cd;
                if (m_tag[ca] == cr) m_busy[ca] = 0;
            end
            if (flush) begin
                for (int i = 0; i < 32; i++) m_busy[i] = 0;
            end else if (we && wa != 0) begin
                m_busy[wa] = 1; m_tag[wa] = wr;
            end
        end
        @(negedge clk);
    endtask

    task automatic idle();
        rst = 0; we = 0; wa = 0; wr = 0; ce = 0; ca = 0; cr = 0; cd = 0; flush = 0;
    endtask

    task automatic rd(input logic [4:0] a1, input logic [4:0] a2);
        re1 = 1; ra1 = a1; re2 = 1; ra2 = a2;
    endtask

    // Constant expectations for the named scenarios, checked before the edge.
    task automatic expect_rd(input string name, input logic r1, input logic [31:0] d1,
                             input logic r2, input logic [31:0] d2);
        #1;
        check({name, "_1"}, {ref1, rd1}, {r1, d1});
        check({name, "_2"}, {ref2, rd2}, {r2, d2});
    endtask

    initial begin
        idle();
        re1 = 0; re2 = 0; ra1 = 0; ra2 = 0;
        @(negedge clk);
        rst = 1; step(); step();
        idle();
        rd(5, 5); expect_rd("reset_r5", 0, 0, 0, 0); step();
        rd(0, 9); re2 = 0; expect_rd("zero_and_disabled", 0, 0, 0, 0); step();

        idle(); rd(5, 5); we = 1; wa = 5; wr = 3; expect_rd("rename_same_cycle", 0, 0, 0, 0); step();
        idle(); rd(5, 5); expect_rd("r5_busy", 1, 3, 1, 3); step();
        ce = 1; ca = 5; cr = 3; cd = 32'hDEADBEEF;
`ifdef REGFILE_COMMIT_BYPASS_EN
        expect_rd("r5_commit_cycle", 0, 32'hDEADBEEF, 0, 32'hDEADBEEF);
`else
        expect_rd("r5_commit_cycle", 1, 3, 1, 3);
`endif
        step();
        idle(); rd(5, 5); expect_rd("r5_committed", 0, 32'hDEADBEEF, 0, 32'hDEADBEEF); step();

        we = 1; wa = 7; wr = 2; step();
        idle(); we = 1; wa = 7; wr = 9; step();
        idle(); ce = 1; ca = 7; cr = 2; cd = 32'h11; step();
        idle(); rd(7, 7); expect_rd("r7_younger_owner", 1, 9, 1, 9); step();
        ce = 1; ca = 7; cr = 9; cd = 32'h22; step();
        idle(); rd(7, 7); expect_rd("r7_final", 0, 32'h22, 0, 32'h22); step();

        we = 1; wa = 0; wr = 4; ce = 1; ca = 0; cd = 32'hFF; step();
        idle(); rd(0, 0); expect_rd("r0_ignored", 0, 0, 0, 0); step();

        we = 1; wa = 1; wr = 1; step();
        idle(); we = 1; wa = 2; wr = 2; step();
        idle(); flush = 1; ce = 1; ca = 1; cr = 1; cd = 32'h5; we = 1; wa = 3; wr = 6; step();
        idle(); rd(1, 2); expect_rd("flush_r1_r2", 0, 32'h5, 0, 0); step();
        rd(3, 3); expect_rd("flush_r3", 0, 0, 0, 0); step();

        we = 1; wa = 4; wr = 8; step();
        idle(); rd(4, 4); ce = 1; ca = 4; cr = 8; cd = 32'h1234;
`ifdef REGFILE_COMMIT_BYPASS_EN
        expect_rd("r4_bypass", 0, 32'h1234, 0, 32'h1234);
`else
        expect_rd("r4_no_bypass", 1, 8, 1, 8);
`endif
        step();
        idle(); rd(4, 4); expect_rd("r4_after", 0, 32'h1234, 0, 32'h1234); step();

        we = 1; wa = 6; wr = 5; ce = 1; ca = 6; cr = 0; cd = 32'hABCD; step();
        idle(); rd(6, 6); expect_rd("rename_beats_commit", 1, 5, 1, 5); step();

        for (int n = 0; n < 800; n++) begin
            rst   = ($urandom_range(0, 99) == 0);
            flush = ($urandom_range(0, 29) == 0);
            re1 = $urandom_range(0, 7) != 0; ra1 = 5'($urandom_range(0, 7));
            re2 = $urandom_range(0, 7) != 0; ra2 = 5'($urandom);
            we = $urandom_range(0, 1) == 1; wa = 5'($urandom_range(0, 7)); wr = 4'($urandom);
            ce = $urandom_range(0, 1) == 1; ca = 5'($urandom_range(0, 7));
            cr = ($urandom_range(0, 9) < 7) ? m_tag[ca] : 4'($urandom);
            cd = $urandom;
            if ($urandom_range(0, 3) == 0) ra1 = ca;
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/reg_ref_file.md
REG_REF_FILE -- requirements
Module: reg_ref_file

Interface
REQ-001 SHALL have port: clk  input  1  system clock, all state updates on rising edge.
REQ-002 SHALL have port: rst  input  1  reset, synchronous, active-high.
REQ-003 SHALL have ports: reg_read_en_1 / reg_read_en_2  input  1  read request from ID, one per port.
REQ-004 SHALL have ports: reg_read_addr_1 / reg_read_addr_2  input  `REG_ADDR_BUS (5)  source register index.
REQ-005 SHALL have ports: reg_read_is_ref_1 / reg_read_is_ref_2  output  1  data field is a ROB tag, not a value.
REQ-006 SHALL have ports: reg_read_data_1 / reg_read_data_2  output  `DATA_BUS (32)  register value, or zero-extended ROB tag when is_ref=1.
REQ-007 SHALL have ports: reg_write_en  input  1, reg_write_addr  input  5, reg_write_ref  input  `ROB_ADDR_BUS  rename request from ID: destination now owned by ROB entry reg_write_ref.
REQ-008 SHALL have ports: commit_en  input  1, commit_addr  input  5, commit_ref  input  `ROB_ADDR_BUS, commit_data  input  32  retirement write from ROB.
REQ-009 SHALL have port: flush  input  1  exception / mispredict recovery, discards all outstanding renames.

Function
REQ-010 SHALL hold 32 entries, each {value[31:0], busy, tag[`ROB_ADDR_BUS]}.
REQ-011 Read ports SHALL be combinational (0-cycle latency) and reflect state before this cycle's edge.
REQ-012 Read with en=0 or addr=0 SHALL return is_ref=0, data=0.
REQ-013 Read of a non-busy entry SHALL return is_ref=0, data=value; busy entry SHALL return is_ref=1, data={zeros,tag}.
REQ-014 Rename (reg_write_en, addr!=0) SHALL set busy=1, tag=reg_write_ref at next edge; value unchanged; addr=0 ignored.
REQ-015 Commit (commit_en, addr!=0) SHALL write value=commit_data; busy SHALL clear only if tag==commit_ref (a younger rename keeps ownership); addr=0 ignored.
REQ-016 Rename and commit to same register same cycle: value SHALL take commit_data, busy=1, tag=reg_write_ref (rename wins ownership).
REQ-017 Flush SHALL clear busy of all 32 entries at next edge; values untouched; a concurrent commit SHALL still write its value; a concurrent rename SHALL be discarded.
REQ-018 Reads in the same cycle as a rename SHALL see pre-rename state (an instruction's sources are never its own destination tag).

Reset
REQ-019 On rst=1 at clk edge: all values=0, busy=0, tag=0; rst dominates rename, commit and flush.
REQ-020 Outputs during/after reset SHALL be is_ref=0, data=0 for all reads.
REQ-021 Reset mid-operation SHALL drop all pending ownership; no commit received that cycle is retained.

Configuration
REQ-022 Macro REGFILE_COMMIT_BYPASS_EN SHALL, when defined, forward same-cycle commits to reads: if read addr==commit_addr!=0, entry busy and tag==commit_ref, return is_ref=0, data=commit_data.
REQ-023 Without REGFILE_COMMIT_BYPASS_EN, reads SHALL return the busy tag that cycle; value visible from next cycle.

Structure
REQ-024 `REG_ADDR_BUS, `DATA_BUS, `ROB_ADDR_BUS and the zero register index SHALL come from shared bus.v; no local redefinition.
REQ-025 One sub-module SHALL exist: RegReadPort (combinational lookup plus optional bypass), instantiated twice.
REQ-026 Storage SHALL be flops (no RAM macro) to allow 32-entry parallel busy clear on flush.

Verification
REQ-027 Reset, then read r5 both ports -> is_ref=0, data=0.
REQ-028 Rename r5 tag 3; next cycle read r5 -> is_ref=1, data=3; commit r5 tag 3 data 0xDEADBEEF; next cycle read -> is_ref=0, data=0xDEADBEEF.
REQ-029 Rename r7 tag 2, then rename r7 tag 9; commit r7 tag 2 data 0x11 -> read r7 is_ref=1, data=9; commit tag 9 data 0x22 -> is_ref=0, data=0x22.
REQ-030 Rename r0 tag 4 and commit r0 data 0xFF -> read r0 is_ref=0, data=0.
REQ-031 Rename r1 tag1, r2 tag2; flush with concurrent commit r1 tag1 data 0x5 and rename r3 tag6 -> r1=0x5, r2 value 0 not busy, r3 not busy.
REQ-032 With bypass on: r4 busy tag 8, commit r4 tag 8 data 0x1234 while reading r4 -> same cycle is_ref=0, data=0x1234; bypass off -> is_ref=1, data=8.
